// File: rtl/scan_addr_gen_pkg.sv
// Shared types and constants for the scan address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package scan_pkg;

   localparam int ADDR_W_DEF  = 4;
   localparam int DWELL_W_DEF = 8;
   localparam int LINES       = 2 ** ADDR_W_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      BLANK = 2'd2
   } state_t;

endpackage

// File: rtl/scan_addr_gen_if.sv
// Control/status bundle between a scan controller and its address generator.
// Latency: n/a (wires only).
// Backpressure: none; start/stop are level requests sampled by the generator.
interface scan_addr_gen_if #(
   parameter int ADDR_W  = scan_pkg::ADDR_W_DEF,
   parameter int DWELL_W = scan_pkg::DWELL_W_DEF
);
   logic               start;
   logic               stop;
   logic               mode;
   logic [DWELL_W-1:0] dwell;
   logic [ADDR_W-1:0]  addr;
   logic               en;
   logic               busy;
   logic               line_tick;
   logic               done;

   modport master (
      output start, stop, mode, dwell,
      input  addr, en, busy, line_tick, done
   );

   modport slave (
      input  start, stop, mode, dwell,
      output addr, en, busy, line_tick, done
   );
endinterface

// File: rtl/scan_addr_gen_dwell_counter.sv
// Loadable down-counter timing how long each line stays selected.
// Latency: o_tc is high in the cycle the count equals 1, i.e. the last dwell cycle.
// Backpressure: none; load has priority over counting, the count parks at 0.
module dwell_counter #(
   parameter int DWELL_W = scan_pkg::DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic [DWELL_W-1:0] i_load_val,
   output logic               o_tc
);

   logic [DWELL_W-1:0] r_count;

   // load on line entry, otherwise count down and hold at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - DWELL_W'(1);
      end
   end

   assign o_tc = (r_count == DWELL_W'(1));

endmodule

// File: rtl/scan_addr_gen.sv
// Walks decoder lines 0..2**ADDR_W-1 holding each for max(dwell,1) cycles; single or continuous sweep.
// Latency: outputs registered; first line appears the cycle after start is accepted in IDLE.
// Backpressure: start ignored while busy, stop aborts from any state. Optional SCAN_BLANK_EN adds a one-cycle en=0 gap between lines.
module scan_addr_gen
   import scan_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   scan_addr_gen_if.slave bus
);

   state_t             r_state;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_en;
   logic               r_busy;
   logic               r_tick;
   logic               r_done;
   logic               r_mode;
   logic [DWELL_W-1:0] r_dwell;

   state_t             w_state_nxt;
   logic [ADDR_W-1:0]  w_addr_nxt;
   logic               w_en_nxt;
   logic               w_busy_nxt;
   logic               w_tick_nxt;
   logic               w_done_nxt;
   logic               w_latch;
   logic               w_cnt_load;
   logic [DWELL_W-1:0] w_cnt_val;
   logic [DWELL_W-1:0] w_dwell_eff;
   logic               w_tc;
   logic               w_last;

   // a dwell of zero behaves as one cycle per line
   assign w_dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
   assign w_last      = &r_addr;

   dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .o_tc       (w_tc)
   );

   // next state and next registered outputs; stop always wins
   always_comb begin
      w_state_nxt = IDLE;
      w_addr_nxt  = '0;
      w_en_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
      w_tick_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_latch     = 1'b0;
      w_cnt_load  = 1'b0;
      w_cnt_val   = r_dwell;
      case (r_state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               w_state_nxt = SCAN;
               w_en_nxt    = 1'b1;
               w_busy_nxt  = 1'b1;
               w_latch     = 1'b1;
               w_cnt_load  = 1'b1;
               w_cnt_val   = w_dwell_eff;
            end
         end
         SCAN: begin
            if (bus.stop) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = '0;
            end else if (w_tc && w_last && !r_mode) begin
               // single sweep finished: the done cycle is already IDLE
               w_done_nxt = 1'b1;
            end else if (w_tc) begin
               // advance; the incrementer wraps 15->0 for continuous mode
               w_addr_nxt = r_addr + ADDR_W'(1);
               w_tick_nxt = 1'b1;
               w_done_nxt = w_last;
               w_busy_nxt = 1'b1;
`ifdef SCAN_BLANK_EN
               w_state_nxt = BLANK;
               w_en_nxt    = 1'b0;
`else
               w_state_nxt = SCAN;
               w_en_nxt    = 1'b1;
               w_cnt_load  = 1'b1;
`endif
            end else begin
               w_state_nxt = SCAN;
               w_addr_nxt  = r_addr;
               w_en_nxt    = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
`ifdef SCAN_BLANK_EN
         BLANK: begin
            if (bus.stop) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = '0;
            end else begin
               w_state_nxt = SCAN;
               w_addr_nxt  = r_addr;
               w_en_nxt    = 1'b1;
               w_busy_nxt  = 1'b1;
               w_cnt_load  = 1'b1;
            end
         end
`endif
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // state, output and sweep-configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_tick  <= 1'b0;
         r_done  <= 1'b0;
         r_mode  <= 1'b0;
         r_dwell <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_en    <= w_en_nxt;
         r_busy  <= w_busy_nxt;
         r_tick  <= w_tick_nxt;
         r_done  <= w_done_nxt;
         if (w_latch) begin
            r_mode  <= bus.mode;
            r_dwell <= w_dwell_eff;
         end
      end
   end

   assign bus.addr      = r_addr;
   assign bus.en        = r_en;
   assign bus.busy      = r_busy;
   assign bus.line_tick = r_tick;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Scoreboard bench for scan_addr_gen: expected per-cycle output traces from a line-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_scan_addr_gen;
   import scan_pkg::*;

`ifdef SCAN_BLANK_EN
   localparam bit BLK = 1'b1;
`else
   localparam bit BLK = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] addr;
      logic       en;
      logic       busy;
      logic       tick;
      logic       done;
   } rec_t;

   localparam rec_t IDLE_R = '0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   rec_t exp_q[$];
   rec_t gen_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   scan_addr_gen_if #(.ADDR_W(4), .DWELL_W(8)) bus ();

   scan_addr_gen #(.ADDR_W(4), .DWELL_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic rec_t mk(input int a, input logic e, input logic b, input logic t, input logic d);
      rec_t r;
      r.addr = 4'(a);
      r.en   = e;
      r.busy = b;
      r.tick = t;
      r.done = d;
      return r;
   endfunction

   function automatic rec_t sample();
      rec_t r;
      r.addr = bus.addr;
      r.en   = bus.en;
      r.busy = bus.busy;
      r.tick = bus.line_tick;
      r.done = bus.done;
      return r;
   endfunction

   task automatic check(input string name, input rec_t act, input rec_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got addr=%0d en=%0b busy=%0b tick=%0b done=%0b, expected addr=%0d en=%0b busy=%0b tick=%0b done=%0b",
                  name, $time, act.addr, act.en, act.busy, act.tick, act.done,
                  exp.addr, exp.en, exp.busy, exp.tick, exp.done);
      end
   endtask

   // monitor: one expected record per cycle while a trace is pending
   always @(negedge clk) begin
      rec_t e;
      if (rst_n && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("trace", sample(), e);
      end
   end

   // one full sweep of the model: every line held deff cycles, optional blank gap before each advance
   task automatic gen_sweep(input int deff, input bit first);
      for (int l = 0; l < LINES; l++) begin
         bit wrap;
         bit adv;
         wrap = (l == 0) && !first;
         adv  = (l > 0) || wrap;
         if (adv && BLK) gen_q.push_back(mk(l, 1'b0, 1'b1, 1'b1, wrap));
         for (int j = 0; j < deff; j++)
            gen_q.push_back(mk(l, 1'b1, 1'b1, (j == 0) && adv && !BLK, (j == 0) && wrap && !BLK));
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) return;
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: %0d records still pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // one sweep; stop_n > 0 asserts stop in active cycle stop_n; inputs are scrambled while busy
   task automatic run(input int d, input bit md, input int stop_n);
      int deff = (d == 0) ? 1 : d;
      int act  = 16 * deff + (BLK ? 15 : 0);
      int total;
      bit first = 1'b1;
      gen_q.delete();
      gen_q.push_back(IDLE_R);
      if (md) begin
         while (gen_q.size() <= stop_n) begin
            gen_sweep(deff, first);
            first = 1'b0;
         end
      end else begin
         gen_sweep(deff, 1'b1);
         gen_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b1));
      end
      if (stop_n > 0) begin
         while (gen_q.size() > stop_n + 1) void'(gen_q.pop_back());
         gen_q.push_back(IDLE_R);
         total = stop_n;
      end else begin
         total = act;
      end
      gen_q.push_back(IDLE_R);

      @(posedge clk); #1;
      foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
      bus.start = 1'b1;
      bus.stop  = 1'b0;
      bus.mode  = md;
      bus.dwell = 8'(d);
      @(posedge clk); #1;
      for (int c = 1; c <= total; c++) begin
         bus.dwell = 8'($urandom);
         bus.mode  = 1'($urandom);
         bus.start = (c <= total - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.stop  = (stop_n > 0) && (c == stop_n);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      wait_drain(total + 40);
   endtask

   // start held high: a second sweep follows straight out of the done cycle
   task automatic held(input int d);
      int deff = (d == 0) ? 1 : d;
      int act  = 16 * deff + (BLK ? 15 : 0);
      gen_q.delete();
      gen_q.push_back(IDLE_R);
      gen_sweep(deff, 1'b1);
      gen_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b1));
      gen_sweep(deff, 1'b1);
      gen_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b1));
      gen_q.push_back(IDLE_R);
      @(posedge clk); #1;
      foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
      bus.mode  = 1'b0;
      bus.dwell = 8'(d);
      bus.start = 1'b1;
      repeat (act + 2) begin
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      wait_drain(2 * act + 40);
   endtask

   task automatic collide_idle();
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) exp_q.push_back(IDLE_R);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      bus.dwell = 8'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      wait_drain(10);
   endtask

   // asynchronous reset while line 5 is selected
   task automatic reset_mid(input int d);
      int n5 = 1 + 5 * d + (BLK ? 5 : 0);
      gen_q.delete();
      gen_q.push_back(IDLE_R);
      gen_sweep(d, 1'b1);
      while (gen_q.size() > n5 + 1) void'(gen_q.pop_back());
      @(posedge clk); #1;
      foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
      bus.mode  = 1'b0;
      bus.dwell = 8'(d);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_drain(n5 + 10);
      #2;
      check("pre_reset_addr5", sample(), mk(5, 1'b1, 1'b1, 1'b0, 1'b0));
      rst_n = 1'b0;
      #1;
      check("async_reset", sample(), IDLE_R);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("held_reset", sample(), IDLE_R);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) exp_q.push_back(IDLE_R);
      wait_drain(50);
   endtask

   initial begin
      int d;
      int deff;
      bit md;
      int act;
      int sn;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.mode  = 1'b0;
      bus.dwell = 8'd0;
      #1;
      check("reset_state", sample(), IDLE_R);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("after_release", sample(), IDLE_R);

      run(2, 1'b0, 0);
      run(0, 1'b0, 0);
      run(1, 1'b1, 40);
      run(3, 1'b0, 1 + 7 * 3 + (BLK ? 7 : 0));
      collide_idle();
      held(1);
      reset_mid(3);

      for (int k = 0; k < 6; k++) begin
         d    = $urandom_range(0, 5);
         deff = (d == 0) ? 1 : d;
         md   = 1'($urandom_range(0, 1));
         act  = 16 * deff + (BLK ? 15 : 0);
         if (md) sn = $urandom_range(20, 120);
         else    sn = ($urandom_range(0, 1) != 0) ? $urandom_range(1, act) : 0;
         run(d, md, sn);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
